// File: rtl/gpio_pkg.sv
// Shared register indices and bus address width for the GPIO controller.
package gpio_pkg;

  localparam int GPIO_ADDR_W = 4;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT     = 4'd0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR     = 4'd1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IN      = 4'd2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_SET     = 4'd3;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_CLR     = 4'd4;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_TGL     = 4'd5;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_RISE_EN = 4'd6;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_FALL_EN = 4'd7;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_STATUS  = 4'd8;

endpackage

// File: rtl/gpio_if.sv
// CPU IO-bus view of the GPIO window: select, register index, strobes and data.
interface gpio_if;
  import gpio_pkg::*;

  logic                   sel;
  logic [GPIO_ADDR_W-1:0] addr;
  logic                   wr_enable;
  logic                   rd_enable;
  logic [31:0]            wdata;
  logic [31:0]            rdata;

  modport master (output sel, addr, wr_enable, rd_enable, wdata, input rdata);
  modport slave  (input sel, addr, wr_enable, rd_enable, wdata, output rdata);

endinterface

// File: rtl/gpio_sync.sv
// Pad input synchroniser with edge detection; edges stay masked until the
// chain has flushed its post-reset contents.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] ARM_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [CNT_W-1:0]                  arm_cnt_q, arm_cnt_d;
  logic                              armed;

  always_comb begin
    chain_d   = {chain_q[SYNC_STAGES-2:0], gpio_in};
    prev_d    = chain_q[SYNC_STAGES-1];
    armed     = (arm_cnt_q == ARM_MAX);
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CNT_W'(1);
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = armed ? (sync & ~prev_q) : '0;
  assign fall = armed ? (~sync & prev_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q   <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      chain_q   <= chain_d;
      prev_q    <= prev_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: output/direction registers with atomic
// SET/CLR/TGL, synchronised readback and edge interrupts with W1C status.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             rst,
  gpio_if.slave            bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] sync, rise, fall;
  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] status_clr;
  logic [31:0]      rd_val;
  logic             wr, rd;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .sync    (sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign wr   = bus.sel & bus.wr_enable;
  assign rd   = bus.sel & bus.rd_enable;
  assign wval = bus.wdata[WIDTH-1:0];

  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    status_clr = '0;
    if (wr) begin
      case (bus.addr)
        GPIO_OUT:     out_d      = wval;
        GPIO_DIR:     dir_d      = wval;
        GPIO_SET:     out_d      = out_q | wval;
        GPIO_CLR:     out_d      = out_q & ~wval;
        GPIO_TGL:     out_d      = out_q ^ wval;
        GPIO_RISE_EN: rise_en_d  = wval;
        GPIO_FALL_EN: fall_en_d  = wval;
        GPIO_STATUS:  status_clr = wval;
        default:      ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident edge wins.
    status_d = (status_q & ~status_clr) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d    = |status_q;
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      GPIO_OUT:     rd_val = 32'(out_q);
      GPIO_DIR:     rd_val = 32'(dir_q);
      GPIO_IN:      rd_val = 32'(sync);
      GPIO_RISE_EN: rd_val = 32'(rise_en_q);
      GPIO_FALL_EN: rd_val = 32'(fall_en_q);
      GPIO_STATUS:  rd_val = 32'(status_q);
      default:      rd_val = '0;
    endcase
    rdata_d = rd ? rd_val : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= RESET_OUT;
      dir_q     <= RESET_DIR;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign irq       = irq_q;

endmodule
